// File: rtl/axi_uart_rx.sv
// axi_uart_rx: UART receiver with an RX FIFO behind an AXI4-lite register port.
//   0x0 RXDATA : [7:0] FIFO head, [31] FIFO empty; a read while not empty pops
//   0x4 STATUS : [0] not empty, [1] full, [2] OVR, [3] FERR, [4] PERR (W1C [4:2])
//   0x8 / 0xC  : read as zero, writes ignored
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit between the
// data bits and the stop bit; without it STATUS[4] always reads 0.
module axi_uart_rx #(
    parameter int CLOCK_FREQUENCY = 500_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH      = 16,
    parameter int AXI_AWIDTH      = 32,
    parameter int AXI_DWIDTH      = 32
) (
    input  logic                  CLK,
    input  logic                  NRST,
    input  logic                  UART_RX_DSER,
    input  logic [AXI_AWIDTH-1:0] AXI_AWADDR,
    input  logic                  AXI_AWVALID,
    output logic                  AXI_AWREADY,
    input  logic [AXI_DWIDTH-1:0] AXI_WDATA,
    input  logic [3:0]            AXI_WSTRB,
    input  logic                  AXI_WVALID,
    output logic                  AXI_WREADY,
    output logic [1:0]            AXI_BRESP,
    output logic                  AXI_BVALID,
    input  logic                  AXI_BREADY,
    input  logic [AXI_AWIDTH-1:0] AXI_ARADDR,
    input  logic                  AXI_ARVALID,
    output logic                  AXI_ARREADY,
    output logic [AXI_DWIDTH-1:0] AXI_RDATA,
    output logic [1:0]            AXI_RRESP,
    output logic                  AXI_RVALID,
    input  logic                  AXI_RREADY,
    output logic                  RX_IRQ
);

    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Even-parity bit that makes the total number of ones in data+parity even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    // Synchroniser and edge detection
    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Receiver
    rx_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
`ifdef UART_RX_PARITY_EN
    logic             par_err_r;
`endif

    // FIFO
    logic [7:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_r;
    logic [PTR_W:0] rd_ptr_r;
    logic [PTR_W:0] wr_ptr_nxt_s;
    logic [PTR_W:0] rd_ptr_nxt_s;

    // Sticky flags
    logic ovr_r;
    logic ferr_r;
    logic perr_r;

    // AXI
    logic        arready_r;
    logic        rvalid_r;
    logic [31:0] rdata_r;
    logic        awready_r;
    logic        bvalid_r;
    logic        irq_r;
    logic [31:0] rd_mux_s;
    logic        rvalid_nxt_s;

    logic fall_s;
    logic bit_end_s;
    logic empty_s;
    logic full_s;
    logic ar_hs_s;
    logic pop_s;
    logic wr_hs_s;
    logic w1c_s;
    logic stop_smp_s;
    logic push_req_s;
    logic push_s;
    logic ovr_set_s;
    logic ferr_set_s;
    logic perr_set_s;

    assign fall_s     = prev_r & ~sync2_r;
    assign bit_end_s  = (cnt_r == BIT_END);
    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign full_s     = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                        (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign ar_hs_s    = AXI_ARVALID & arready_r;
    assign pop_s      = ar_hs_s & (AXI_ARADDR[3:2] == 2'b00) & ~empty_s;
    assign wr_hs_s    = awready_r & AXI_AWVALID & AXI_WVALID;
    assign w1c_s      = wr_hs_s & (AXI_AWADDR[3:2] == 2'b01);
    assign stop_smp_s = (state_r == ST_STOP) & bit_end_s;
    assign ferr_set_s = stop_smp_s & ~sync2_r;
`ifdef UART_RX_PARITY_EN
    assign push_req_s = stop_smp_s & sync2_r & ~par_err_r;
    assign perr_set_s = stop_smp_s & sync2_r & par_err_r;
`else
    assign push_req_s = stop_smp_s & sync2_r;
    assign perr_set_s = 1'b0;
`endif
    // A full FIFO still accepts a byte when the head is popped in the same cycle.
    assign push_s       = push_req_s & (~full_s | pop_s);
    assign ovr_set_s    = push_req_s & full_s & ~pop_s;
    assign rvalid_nxt_s = ar_hs_s | (rvalid_r & ~AXI_RREADY);

    assign AXI_AWREADY = awready_r;
    assign AXI_WREADY  = awready_r;
    assign AXI_BVALID  = bvalid_r;
    assign AXI_BRESP   = 2'b00;
    assign AXI_ARREADY = arready_r;
    assign AXI_RVALID  = rvalid_r;
    assign AXI_RDATA   = rdata_r;
    assign AXI_RRESP   = 2'b00;
    assign RX_IRQ      = irq_r;

    logic unused_s;
    assign unused_s = ^{AXI_WSTRB, AXI_AWADDR[AXI_AWIDTH-1:4], AXI_AWADDR[1:0],
                        AXI_ARADDR[AXI_AWIDTH-1:4], AXI_ARADDR[1:0],
                        AXI_WDATA[AXI_DWIDTH-1:5], AXI_WDATA[1:0]};

    // Register read multiplexer, decoded on address bits [3:2].
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (AXI_ARADDR[3:2])
            2'b00: begin
                if (empty_s) begin
                    rd_mux_s = 32'h8000_0000;
                end else begin
                    rd_mux_s = {24'h00_0000, mem_r[rd_ptr_r[PTR_W-1:0]]};
                end
            end
            2'b01:   rd_mux_s = {27'h000_0000, perr_r, ferr_r, ovr_r, full_s, ~empty_s};
            default: rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Next FIFO pointer values, also used to register the interrupt.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Two-flop synchroniser plus previous-value register for edge detection; idles high.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= UART_RX_DSER;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Receive FSM: start detect, mid-bit sampling, LSB-first shift, stop check.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
`ifdef UART_RX_PARITY_EN
            par_err_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r     <= '0;
                    bit_cnt_r <= 3'd0;
                    // Only a falling edge starts a frame, so a held-low line never retriggers.
                    if (fall_s) begin
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_r == HALF_END) begin
                        cnt_r   <= '0;
                        state_r <= sync2_r ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        cnt_r     <= '0;
                        shift_r   <= {sync2_r, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_r <= ST_PARITY;
`else
                            state_r <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end_s) begin
                        cnt_r     <= '0;
                        par_err_r <= even_parity(shift_r) ^ sync2_r;
                        state_r   <= ST_STOP;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end_s) begin
                        cnt_r   <= '0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    cnt_r   <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= shift_r;
        end
    end

    // FIFO pointers and the not-empty interrupt.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            irq_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            irq_r    <= (wr_ptr_nxt_s != rd_ptr_nxt_s);
        end
    end

    // Sticky error flags; a set in the same cycle as a W1C clear wins.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            ovr_r  <= 1'b0;
            ferr_r <= 1'b0;
            perr_r <= 1'b0;
        end else begin
            ovr_r  <= ovr_set_s  | (ovr_r  & ~(w1c_s & AXI_WDATA[2]));
            ferr_r <= ferr_set_s | (ferr_r & ~(w1c_s & AXI_WDATA[3]));
            perr_r <= perr_set_s | (perr_r & ~(w1c_s & AXI_WDATA[4]));
        end
    end

    // AXI read channel: one-cycle latency, data held until RREADY.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0000_0000;
        end else begin
            rvalid_r  <= rvalid_nxt_s;
            arready_r <= ~rvalid_nxt_s;
            if (ar_hs_s) begin
                rdata_r <= rd_mux_s;
            end
        end
    end

    // AXI write channel: single-cycle AW/W ready once both are valid, then B response.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            awready_r <= 1'b0;
            bvalid_r  <= 1'b0;
        end else begin
            awready_r <= AXI_AWVALID & AXI_WVALID & ~bvalid_r & ~awready_r;
            bvalid_r  <= wr_hs_s | (bvalid_r & ~AXI_BREADY);
        end
    end

endmodule
